// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, default memory size
// and the address-legality rule.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic [31:0] DMEM_ADDR_LIMIT = 32'h0000_0400;

    // Misaligned or beyond the last whole word; limit is assumed to be at least 4.
    function automatic logic addr_illegal(input logic [31:0] addr, input logic [31:0] limit);
        return (addr[1:0] != 2'b00) || (addr > (limit - 32'd4));
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: on contention the port that was not granted last wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            gnt = last ? 2'b01 : 2'b10;
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: one access at a time through IDLE -> ACCESS -> RESP,
// with round-robin selection and range/alignment checking.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter logic [31:0] ADDR_LIMIT = DMEM_ADDR_LIMIT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_req,
    input  logic        p1_req,
    input  logic        p0_we,
    input  logic        p1_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p0_wdata,
    input  logic [31:0] p1_wdata,
    output logic        p0_gnt,
    output logic        p1_gnt,
    output logic        p0_rvalid,
    output logic        p1_rvalid,
    output logic        p0_err,
    output logic        p1_err,
    output logic [31:0] p0_rdata,
    output logic [31:0] p1_rdata,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    state_t      state_q, state_d;
    logic        last_q, last_d;
    logic        port_q, port_d;
    logic        we_q, we_d;
    logic        err_q, err_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;

    logic [1:0]  arb_gnt;
    logic        grant_now;
    logic [31:0] sel_addr;

    rr_arb2 u_rr_arb2 (
        .req  ({p1_req, p0_req}),
        .last (last_q),
        .gnt  (arb_gnt)
    );

    // Gated by rst so the grant reads 0 while reset is held, even with requests up.
    assign grant_now = rst && (state_q == ST_IDLE) && (arb_gnt != 2'b00);
    assign sel_addr  = arb_gnt[1] ? p1_addr : p0_addr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            port_q  <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            port_q  <= port_d;
            we_q    <= we_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (p0_req || p1_req) state_d = ST_ACCESS;
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        last_d  = last_q;
        port_d  = port_q;
        we_d    = we_q;
        err_d   = err_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        if (grant_now) begin
            last_d  = arb_gnt[1];
            port_d  = arb_gnt[1];
            we_d    = arb_gnt[1] ? p1_we : p0_we;
            addr_d  = sel_addr;
            wdata_d = arb_gnt[1] ? p1_wdata : p0_wdata;
            err_d   = addr_illegal(sel_addr, ADDR_LIMIT);
        end
        // Only a legal read returns memory data; writes and errors respond with zero.
        if (state_q == ST_ACCESS) begin
            rdata_d = (!we_q && !err_q) ? mem_rdata : 32'd0;
        end
    end

    always_comb begin
        p0_gnt    = grant_now && arb_gnt[0];
        p1_gnt    = grant_now && arb_gnt[1];
        mem_we    = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        p0_rvalid = 1'b0;
        p1_rvalid = 1'b0;
        p0_err    = 1'b0;
        p1_err    = 1'b0;
        p0_rdata  = 32'd0;
        p1_rdata  = 32'd0;
        if (state_q == ST_ACCESS) begin
            mem_we    = we_q && !err_q;
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
        end
        if (state_q == ST_RESP) begin
            if (port_q) begin
                p1_rvalid = 1'b1;
                p1_err    = err_q;
                p1_rdata  = rdata_q;
            end else begin
                p0_rvalid = 1'b1;
                p0_err    = err_q;
                p0_rdata  = rdata_q;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural word memory behind the command port.
`timescale 1ns/1ps
module tb_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic        p0_req, p1_req, p0_we, p1_we;
    logic [31:0] p0_addr, p1_addr, p0_wdata, p1_wdata;
    logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem_model [256];

    int n_checks = 0;
    int n_errors = 0;

    dmem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .p0_req    (p0_req),
        .p1_req    (p1_req),
        .p0_we     (p0_we),
        .p1_we     (p1_we),
        .p0_addr   (p0_addr),
        .p1_addr   (p1_addr),
        .p0_wdata  (p0_wdata),
        .p1_wdata  (p1_wdata),
        .p0_gnt    (p0_gnt),
        .p1_gnt    (p1_gnt),
        .p0_rvalid (p0_rvalid),
        .p1_rvalid (p1_rvalid),
        .p0_err    (p0_err),
        .p1_err    (p1_err),
        .p0_rdata  (p0_rdata),
        .p1_rdata  (p1_rdata),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem_model[mem_addr[9:2]];
    always @(posedge clk) begin
        if (mem_we) mem_model[mem_addr[9:2]] <= mem_wdata;
    end

    typedef struct {
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        p0_req = 0; p1_req = 0; p0_we = 0; p1_we = 0;
        p0_addr = 0; p1_addr = 0; p0_wdata = 0; p1_wdata = 0;
    endtask

    // One isolated access: grant at T, memory command at T+1, response at T+2.
    task automatic run_txn(input vec_t v);
        logic exp_mwe;
        exp_mwe = v.we && !v.exp_err;
        @(posedge clk); #1;
        if (v.port) begin
            p1_req = 1; p1_we = v.we; p1_addr = v.addr; p1_wdata = v.wdata;
        end else begin
            p0_req = 1; p0_we = v.we; p0_addr = v.addr; p0_wdata = v.wdata;
        end
        #1;
        check("gnt_p0", {31'd0, p0_gnt}, {31'd0, !v.port});
        check("gnt_p1", {31'd0, p1_gnt}, {31'd0, v.port});
        @(posedge clk); #1;
        // Drop and scramble the request to show the granted values were latched.
        p0_req = 0; p1_req = 0; p0_we = !v.we; p1_we = !v.we;
        p0_addr = 32'hBAD0_0001; p1_addr = 32'hBAD0_0001; p0_wdata = 0; p1_wdata = 0;
        #1;
        check("access_mem_we", {31'd0, mem_we}, {31'd0, exp_mwe});
        check("access_mem_addr", mem_addr, v.addr);
        if (exp_mwe) check("access_mem_wdata", mem_wdata, v.wdata);
        check("access_no_rvalid", {30'd0, p1_rvalid, p0_rvalid}, 32'd0);
        @(posedge clk); #2;
        check("resp_rvalid", {30'd0, p1_rvalid, p0_rvalid}, v.port ? 32'd2 : 32'd1);
        check("resp_err", {31'd0, v.port ? p1_err : p0_err}, {31'd0, v.exp_err});
        check("resp_rdata", v.port ? p1_rdata : p0_rdata, v.exp_rdata);
        $display("txn p%0d %s addr=%h wdata=%h -> err=%0d rdata=%h", v.port, v.we ? "W" : "R",
                 v.addr, v.wdata, v.port ? p1_err : p0_err, v.port ? p1_rdata : p0_rdata);
        clear_inputs();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_model[i] = 32'd0;

        vecs[0] = '{1'b0, 1'b1, 32'h0000_000C, 32'hDEAD_BEEF, 1'b0, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_000C, 32'h0,         1'b0, 32'hDEAD_BEEF};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_000E, 32'h0,         1'b1, 32'h0};
        vecs[3] = '{1'b0, 1'b1, 32'h0000_0400, 32'h1111_1111, 1'b1, 32'h0};
        vecs[4] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 32'h2222_2222, 1'b1, 32'h0};
        vecs[5] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h0};
        vecs[6] = '{1'b0, 1'b0, 32'h0000_03FC, 32'h0,         1'b0, 32'h0};
        vecs[7] = '{1'b1, 1'b1, 32'h0000_03FC, 32'hA5A5_A5A5, 1'b0, 32'h0};
        vecs[8] = '{1'b0, 1'b0, 32'h0000_03FC, 32'h0,         1'b0, 32'hA5A5_A5A5};
        vecs[9] = '{1'b1, 1'b0, 32'h0000_03FD, 32'h0,         1'b1, 32'h0};

        // Reset state, with requests present to show grants are forced low.
        clear_inputs();
        rst = 0;
        p0_req = 1; p1_req = 1;
        #12;
        check("reset_gnt", {30'd0, p1_gnt, p0_gnt}, 32'd0);
        check("reset_rvalid", {30'd0, p1_rvalid, p0_rvalid}, 32'd0);
        check("reset_err", {30'd0, p1_err, p0_err}, 32'd0);
        check("reset_rdata", p0_rdata | p1_rdata, 32'd0);
        check("reset_mem_cmd", {31'd0, mem_we} | mem_addr | mem_wdata, 32'd0);
        clear_inputs();
        @(posedge clk); #1;
        rst = 1;

        for (int i = 0; i < 10; i++) run_txn(vecs[i]);

        // Both ports request continuously from reset: p0,p1,p0,p1 every 3 cycles.
        @(posedge clk); #1;
        rst = 0;
        #1;
        @(posedge clk); #1;
        rst = 1;
        p0_req = 1; p1_req = 1;
        p0_addr = 32'h0000_000C; p1_addr = 32'h0000_000C;
        for (int k = 0; k < 12; k++) begin
            logic [1:0] exp_g;
            logic [1:0] exp_v;
            exp_g = 2'b00;
            exp_v = 2'b00;
            if (k % 3 == 0) exp_g = ((k / 3) % 2 == 0) ? 2'b01 : 2'b10;
            if (k % 3 == 2) exp_v = (((k - 2) / 3) % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            check($sformatf("rr_gnt_c%0d", k), {30'd0, p1_gnt, p0_gnt}, {30'd0, exp_g});
            check($sformatf("rr_rvalid_c%0d", k), {30'd0, p1_rvalid, p0_rvalid}, {30'd0, exp_v});
            if (exp_g != 2'b00)
                $display("txn rr cycle %0d grant p%0d", k, exp_g[1]);
            @(posedge clk); #1;
        end
        clear_inputs();

        // Reset in the ACCESS cycle of a p0 write: write dropped, p0 wins afterwards.
        @(posedge clk); #1;
        p0_req = 1; p0_we = 1; p0_addr = 32'h0000_0020; p0_wdata = 32'hCAFE_F00D;
        #1;
        check("rst_wr_gnt", {31'd0, p0_gnt}, 32'd1);
        @(posedge clk); #1;
        clear_inputs();
        #1;
        check("rst_wr_mem_we_before", {31'd0, mem_we}, 32'd1);
        #1;
        rst = 0;
        #1;
        check("rst_wr_mem_we_after", {31'd0, mem_we}, 32'd0);
        check("rst_wr_mem_addr_after", mem_addr | mem_wdata, 32'd0);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #2;
            check("rst_wr_no_rvalid", {30'd0, p1_rvalid, p0_rvalid}, 32'd0);
        end
        #1;
        rst = 1;
        p0_req = 1; p1_req = 1; p0_addr = 32'h0000_0020; p1_addr = 32'h0000_0020;
        #1;
        check("rst_next_gnt", {30'd0, p1_gnt, p0_gnt}, 32'd1);
        @(posedge clk); #1;
        clear_inputs();
        @(posedge clk); #2;
        check("rst_next_rvalid", {30'd0, p1_rvalid, p0_rvalid}, 32'd1);
        check("rst_discarded_write", p0_rdata, 32'd0);
        $display("txn reset-mid-write then p0 R addr=00000020 -> rdata=%h", p0_rdata);

        @(posedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_LIMIT, default 32'h400, meaning data-memory size in bytes; legal word addresses are 0 to ADDR_LIMIT-4.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have ports p0_req, p1_req, input, 1 each, meaning access request (p0 is the core load/store path, p1 is the loader/debug port).
REQ-005 SHALL have ports p0_we, p1_we, input, 1 each, meaning 1 for a write and 0 for a read.
REQ-006 SHALL have ports p0_addr, p1_addr, input, 32 each, meaning byte address.
REQ-007 SHALL have ports p0_wdata, p1_wdata, input, 32 each, meaning write data.
REQ-008 SHALL have ports p0_gnt, p1_gnt, output, 1 each, meaning request accepted this cycle.
REQ-009 SHALL have ports p0_rvalid, p1_rvalid, output, 1 each, meaning response pulse.
REQ-010 SHALL have ports p0_err, p1_err, output, 1 each, meaning response is an error; valid with rvalid.
REQ-011 SHALL have ports p0_rdata, p1_rdata, output, 32 each, meaning read data; valid with rvalid.
REQ-012 SHALL have ports mem_we, output, 1; mem_addr, output, 32; mem_wdata, output, 32, forming the memory command.
REQ-013 SHALL have port mem_rdata, input, 32, meaning combinational read data from memory.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, ACCESS, RESP.
- Transitions: IDLE->ACCESS on any req; ACCESS->RESP always; RESP->IDLE always.
REQ-015 SHALL assert exactly one gnt, combinationally, only in IDLE with a req present; gnt SHALL be 0 in ACCESS and RESP.
REQ-016 SHALL arbitrate round-robin: on simultaneous requests the port not granted last wins; a single requester always wins.
REQ-017 SHALL register the winner's we/addr/wdata/port id on the grant edge; requesters hold req/we/addr/wdata stable until gnt and may drop or change them after.
REQ-018 SHALL in ACCESS drive mem_addr/mem_wdata from the latched values, and assert mem_we for one cycle only for a legal write.
REQ-019 SHALL for a legal read capture mem_rdata at the end of ACCESS.
REQ-020 SHALL in RESP pulse rvalid for one cycle on the granted port only.
- Latency: grant in cycle T -> rvalid in cycle T+2.
- Throughput: at most one access per 3 cycles.
REQ-021 SHALL flag illegal accesses: addr[1:0]!=0, or addr > ADDR_LIMIT-4 (unsigned 32-bit compare, no wrap).
- Illegal access: mem_we stays 0, err=1, rdata=0.
REQ-022 SHALL return rdata=0 for writes, and err=0 for legal accesses.
REQ-023 SHALL drive mem_we=0 and mem_addr/mem_wdata=0 outside ACCESS.
REQ-024 SHALL ignore requests arriving in ACCESS/RESP; they are arbitrated in the next IDLE cycle.

Reset
REQ-025 SHALL on rst=0 immediately force state=IDLE and last-granted=p1 (so p0 wins first), and force all outputs to 0: gnt, rvalid, err, rdata, mem_we, mem_addr, mem_wdata.
REQ-026 SHALL discard an in-flight access if reset occurs mid-operation: no rvalid is produced, and a pending mem_we is deasserted asynchronously.

Structure
REQ-027 SHALL take state encodings (IDLE/ACCESS/RESP) and the default ADDR_LIMIT from a shared package, dmem_pkg.
REQ-028 SHALL place the round-robin winner selection in one sub-module, rr_arb2 (2 requests, last-grant input, one-hot grant output).

Verification
REQ-029 Bench SHALL cover the following scenarios:
- p0 write addr 0x0C data 0xDEADBEEF -> gnt T, mem_we=1 with mem_addr=0x0C at T+1, p0_rvalid T+2 with err=0; then p1 read 0x0C -> p1_rdata=0xDEADBEEF.
- p0 and p1 request every cycle after reset -> grants alternate p0,p1,p0,p1, one every 3 cycles.
- p1 read addr 0x0E -> p1_rvalid with err=1, rdata=0, no mem_we.
- p0 write addr 0x400 (and 0xFFFFFFFC) -> err=1, memory unchanged.
- rst asserted during ACCESS of a write -> mem_we drops immediately, no rvalid, next grant goes to p0.
- p0 drops req the cycle after gnt -> response still delivered at T+2.
